// File: rtl/fir_decim_axis.sv
// fir_decim_axis: runtime-programmable transposed-form FIR with integer decimation and AXI-Stream handshake.
// Define FIR_SATURATE_EN to clamp the shifted result to OUT_WIDTH instead of wrapping.
module fir_decim_axis #(
    parameter int NUM_TAPS    = 15,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 8,
    parameter int OUT_WIDTH   = 32,
    parameter int OUT_SHIFT   = 0,
    parameter int DECIM       = 1
) (
    input  logic                          clk,
    input  logic                          rst_in,
    input  logic                          s_tvalid,
    input  logic signed [DATA_WIDTH-1:0]  s_tdata,
    input  logic                          s_tlast,
    output logic                          s_tready,
    output logic                          m_tvalid,
    output logic signed [OUT_WIDTH-1:0]   m_tdata,
    output logic                          m_tlast,
    input  logic                          m_tready,
    input  logic                          coeff_wr,
    input  logic [$clog2(NUM_TAPS)-1:0]   coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0] coeff_data
);
    localparam int ACC_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(NUM_TAPS);
    localparam int PW        = DECIM > 1 ? $clog2(DECIM) : 1;
`ifdef FIR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic signed [COEFF_WIDTH-1:0] r_coeff [NUM_TAPS];
    logic signed [ACC_WIDTH-1:0]   r_z     [1:NUM_TAPS-1];
    logic signed [ACC_WIDTH-1:0]   w_prod  [NUM_TAPS];
    logic signed [ACC_WIDTH-1:0]   w_x, w_y, w_sh;
    logic signed [OUT_WIDTH-1:0]   w_res;
    logic signed [OUT_WIDTH-1:0]   r_data;
    logic [PW-1:0]                 r_phase;
    logic                          r_valid, r_last;
    logic                          w_accept, w_emit;

    assign s_tready = !r_valid || m_tready;
    assign w_accept = s_tvalid && s_tready;
    assign w_emit   = w_accept && (r_phase == PW'(DECIM - 1) || s_tlast);
    assign w_x      = ACC_WIDTH'(s_tdata);

    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) w_prod[k] = ACC_WIDTH'(r_coeff[k]) * w_x;
    end

    assign w_y  = w_prod[0] + r_z[1];
    assign w_sh = w_y >>> OUT_SHIFT;

    // Clamp only matters when the output is narrower than the accumulator.
    generate
        if (SAT && OUT_WIDTH < ACC_WIDTH) begin : g_sat
            logic w_ovf;
            assign w_ovf = |w_sh[ACC_WIDTH-1:OUT_WIDTH-1] && !(&w_sh[ACC_WIDTH-1:OUT_WIDTH-1]);
            assign w_res = w_ovf ? {w_sh[ACC_WIDTH-1], {(OUT_WIDTH-1){!w_sh[ACC_WIDTH-1]}}}
                                 : w_sh[OUT_WIDTH-1:0];
        end else begin : g_cast
            assign w_res = OUT_WIDTH'(w_sh);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < NUM_TAPS; k++) r_coeff[k] <= (k == 0) ? COEFF_WIDTH'(1) : '0;
        end else if (coeff_wr && 32'(coeff_addr) < NUM_TAPS) begin
            r_coeff[coeff_addr] <= coeff_data;
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 1; k < NUM_TAPS; k++) r_z[k] <= '0;
        end else if (w_accept) begin
            for (int k = 1; k < NUM_TAPS - 1; k++) r_z[k] <= w_prod[k] + r_z[k+1];
            r_z[NUM_TAPS-1] <= w_prod[NUM_TAPS-1];
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_phase <= '0;
        end else if (w_accept) begin
            r_phase <= w_emit ? '0 : r_phase + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (w_emit) begin
            r_valid <= 1'b1;
            r_data  <= w_res;
            r_last  <= s_tlast;
        end else if (m_tready) begin
            r_valid <= 1'b0;
        end
    end

    assign m_tvalid = r_valid;
    assign m_tdata  = r_data;
    assign m_tlast  = r_last;
endmodule

// File: tb/tb_fir_decim_axis.sv
// tb_fir_decim_axis: two instances (DECIM=1/OUT_WIDTH=32 and DECIM=3/OUT_WIDTH=16) against a product-history model.
module tb_fir_decim_axis;
    localparam int NT = 15;
    localparam int DEC [2] = '{1, 3};
    localparam int OW  [2] = '{32, 16};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_in, s_tvalid, s_tlast, m_tready, coeff_wr;
    logic signed [15:0] s_tdata;
    logic [3:0] coeff_addr;
    logic signed [7:0] coeff_data;
    logic sr_a, sr_b, mv_a, mv_b, ml_a, ml_b;
    logic signed [31:0] md_a;
    logic signed [15:0] md_b;
    logic sr [2], mv [2], ml [2];
    longint md [2];

    always_comb begin
        sr[0] = sr_a; sr[1] = sr_b;
        mv[0] = mv_a; mv[1] = mv_b;
        ml[0] = ml_a; ml[1] = ml_b;
        md[0] = longint'(md_a);
        md[1] = longint'(md_b);
    end

    fir_decim_axis u_a (
        .clk(clk), .rst_in(rst_in), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .s_tready(sr_a), .m_tvalid(mv_a), .m_tdata(md_a), .m_tlast(ml_a), .m_tready(m_tready),
        .coeff_wr(coeff_wr), .coeff_addr(coeff_addr), .coeff_data(coeff_data)
    );

    fir_decim_axis #(.OUT_WIDTH(16), .DECIM(3)) u_b (
        .clk(clk), .rst_in(rst_in), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .s_tready(sr_b), .m_tvalid(mv_b), .m_tdata(md_b), .m_tlast(ml_b), .m_tready(m_tready),
        .coeff_wr(coeff_wr), .coeff_addr(coeff_addr), .coeff_data(coeff_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Model: every accepted sample keeps its own product vector h[k]*x; y sums tap k of the sample k steps old.
    longint h  [2][NT];
    longint pr [2][NT][NT];
    int     ph [2];
    bit     ev [2], el [2];
    longint ed [2];
    longint logd [2][$];
    bit     logl [2][$];

    function automatic longint fmt(input longint y, input int ow);
        longint lo, hi, v;
        lo = -(longint'(1) <<< (ow - 1));
        hi = -lo - 1;
`ifdef FIR_SATURATE_EN
        v = y > hi ? hi : (y < lo ? lo : y);
`else
        v = y & ((longint'(1) <<< ow) - 1);
        if (v > hi) v -= longint'(1) <<< ow;
`endif
        return v;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_in) begin
                for (int k = 0; k < NT; k++) begin
                    h[i][k] = (k == 0) ? 1 : 0;
                    for (int a = 0; a < NT; a++) pr[i][a][k] = 0;
                end
                ph[i] = 0; ev[i] = 0; ed[i] = 0; el[i] = 0;
                logd[i].delete();
                logl[i].delete();
                check($sformatf("rst_valid%0d", i), longint'(mv[i]), 0);
                check($sformatf("rst_data%0d", i), md[i], 0);
            end else begin
                bit rdy, emit;
                longint y;
                check($sformatf("valid%0d", i), longint'(mv[i]), longint'(ev[i]));
                rdy = !ev[i] || m_tready;
                check($sformatf("ready%0d", i), longint'(sr[i]), longint'(rdy));
                if (ev[i]) begin
                    check($sformatf("data%0d", i), md[i], ed[i]);
                    check($sformatf("last%0d", i), longint'(ml[i]), longint'(el[i]));
                end
                if (ev[i] && m_tready) begin
                    logd[i].push_back(ed[i]);
                    logl[i].push_back(el[i]);
                end
                if (s_tvalid && rdy) begin
                    for (int a = NT - 1; a > 0; a--) pr[i][a] = pr[i][a-1];
                    for (int k = 0; k < NT; k++) pr[i][0][k] = h[i][k] * longint'(s_tdata);
                    y = 0;
                    for (int k = 0; k < NT; k++) y += pr[i][k][k];
                    emit = (ph[i] == DEC[i] - 1) || s_tlast;
                    ph[i] = emit ? 0 : ph[i] + 1;
                    if (emit) begin
                        ev[i] = 1; ed[i] = fmt(y, OW[i]); el[i] = s_tlast;
                    end else if (m_tready) ev[i] = 0;
                end else if (m_tready) ev[i] = 0;
                if (coeff_wr && coeff_addr < NT) h[i][coeff_addr] = longint'(coeff_data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        s_tvalid = 0; coeff_wr = 0; s_tlast = 0;
        rst_in = 1;
        #1;
        check("rst_now_a", longint'(mv[0]), 0);
        check("rst_now_b", longint'(mv[1]), 0);
        cyc();
        rst_in = 0;
    endtask

    task automatic send(input int x, input bit last);
        s_tvalid = 1; s_tdata = 16'(x); s_tlast = last;
        cyc();
        s_tvalid = 0; s_tlast = 0;
    endtask

    task automatic wr(input int a, input int d);
        coeff_wr = 1; coeff_addr = 4'(a); coeff_data = 8'(d);
        cyc();
        coeff_wr = 0;
    endtask

    task automatic chk_log(input int i, input string tag, input int n,
                           input longint a, input longint b, input longint c, input longint d, input int lm);
        longint e [4];
        e = '{a, b, c, d};
        check({tag, "_n"}, longint'(logd[i].size()), longint'(n));
        for (int j = 0; j < n && j < logd[i].size(); j++) begin
            check($sformatf("%s_d%0d", tag, j), logd[i][j], e[j]);
            check($sformatf("%s_l%0d", tag, j), longint'(logl[i][j]), longint'(lm[j]));
        end
    endtask

    initial begin
        rst_in = 1; s_tvalid = 0; s_tdata = 0; s_tlast = 0; m_tready = 1;
        coeff_wr = 0; coeff_addr = 0; coeff_data = 0;
        idle(3);
        rst_in = 0;

        do_reset();
        send(5, 0);
        check("lat_valid", longint'(mv[0]), 1);
        check("lat_data", md[0], 5);
        send(-3, 0);
        send(7, 0);
        idle(3);
        chk_log(0, "p1a", 3, 5, -3, 7, 0, 0);
        chk_log(1, "p1b", 1, 7, 0, 0, 0, 0);

        do_reset();
        wr(0, 1); wr(1, 2); wr(2, 3);
        send(100, 0); send(0, 0); send(0, 0); send(0, 0);
        idle(3);
        chk_log(0, "p2a", 4, 100, 200, 300, 0, 0);
        chk_log(1, "p2b", 1, 300, 0, 0, 0, 0);

        do_reset();
        for (int k = 0; k < NT; k++) wr(k, 1);
        for (int k = 1; k <= 6; k++) send(k, 0);
        idle(3);
        chk_log(1, "p3b", 2, 6, 21, 0, 0, 0);

        do_reset();
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        idle(2);
        send(5, 0); send(6, 0);
        idle(2);
        check("p4_gap", longint'(logd[1].size()), 2);
        send(7, 0);
        idle(3);
        chk_log(1, "p4b", 3, 3, 4, 7, 0, 2);

        do_reset();
        wr(0, 127);
        send(32767, 1);
        idle(3);
        chk_log(0, "p5a", 1, 4161409, 0, 0, 0, 1);
`ifdef FIR_SATURATE_EN
        chk_log(1, "p5b", 1, 32767, 0, 0, 0, 1);
`else
        chk_log(1, "p5b", 1, 32641, 0, 0, 0, 1);
`endif

        do_reset();
        m_tready = 0; s_tvalid = 1; s_tdata = 11; s_tlast = 1;
        cyc();
        s_tdata = 12;
        for (int c = 0; c < 10; c++) begin
            cyc();
            check("stall_rdy", longint'(sr[0]), 0);
            check("stall_vld", longint'(mv[0]), 1);
            check("stall_dat", md[0], 11);
        end
        m_tready = 1;
        cyc();
        s_tvalid = 0; s_tlast = 0;
        idle(3);
        chk_log(0, "p6a", 2, 11, 12, 0, 0, 3);
        chk_log(1, "p6b", 2, 11, 12, 0, 0, 3);

        wr(0, 2);
        send(3, 0); send(4, 0);
        check("p7_inflight", longint'(mv[0]), 1);
        do_reset();
        send(9, 1);
        idle(3);
        chk_log(0, "p7a", 1, 9, 0, 0, 0, 1);
        chk_log(1, "p7b", 1, 9, 0, 0, 0, 1);

        for (int c = 0; c < 3000; c++) begin
            s_tvalid   = $urandom_range(0, 3) != 0;
            s_tdata    = ($urandom_range(0, 7) == 0) ? -16'sd32768 : 16'($urandom);
            s_tlast    = $urandom_range(0, 7) == 0;
            m_tready   = $urandom_range(0, 3) != 0;
            coeff_wr   = $urandom_range(0, 15) == 0;
            coeff_addr = 4'($urandom);
            coeff_data = ($urandom_range(0, 3) == 0) ? -8'sd128 : 8'($urandom);
            cyc();
        end
        s_tvalid = 0; coeff_wr = 0; m_tready = 1;
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
